// File: rtl/dma_w_burst_ctrl_if.sv
// dma_w_burst_ctrl_if: bundles the register-block, source-FIFO and write-engine
// signals of the write burst scheduler.
//   cfg_*      : transfer request from the register block (start, addr, words)
//   busy/done/error : status back to the register block
//   src_*      : source FIFO beat, occupancy and pop
//   eng_*      : burst request, write data/strobe and engine handshake/status
// Modports: slave = the scheduler, master = everything around it.
interface dma_w_burst_ctrl_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 8,
   parameter int unsigned XFER_W = 16
);
   logic                  cfg_start;
   logic [ADDR_W-1:0]     cfg_addr;
   logic [XFER_W-1:0]     cfg_words;
   logic                  busy;
   logic                  done;
   logic                  error;
   logic                  src_valid;
   logic [DATA_W-1:0]     src_data;
   logic [XFER_W-1:0]     src_level;
   logic                  src_ready;
   logic                  eng_valid;
   logic [ADDR_W-1:0]     eng_addr;
   logic [LEN_W-1:0]      eng_len;
   logic [DATA_W-1:0]     eng_wdata;
   logic [DATA_W/8-1:0]   eng_wstrb;
   logic                  eng_ready;
   logic                  eng_dma_ready;
   logic                  eng_error;

   modport slave (
      input  cfg_start, cfg_addr, cfg_words,
      output busy, done, error,
      input  src_valid, src_data, src_level,
      output src_ready,
      output eng_valid, eng_addr, eng_len, eng_wdata, eng_wstrb,
      input  eng_ready, eng_dma_ready, eng_error
   );

   modport master (
      output cfg_start, cfg_addr, cfg_words,
      input  busy, done, error,
      output src_valid, src_data, src_level,
      input  src_ready,
      input  eng_valid, eng_addr, eng_len, eng_wdata, eng_wstrb,
      output eng_ready, eng_dma_ready, eng_error
   );
endinterface

// File: rtl/dma_w_burst_ctrl.sv
// dma_w_burst_ctrl: splits one software write transfer (start address + word
// count) into AXI INCR bursts capped by MAX_BURST, the words remaining and the
// next 4 KB boundary, issues each burst to the write engine, pipes source beats
// through and sequences the engine response, accumulating a sticky error.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : dma_w_burst_ctrl_if.slave (cfg_*, busy/done/error, src_*, eng_*)
// Build option:
//   DMA_W_ERR_ABORT_EN : an engine error ends the transfer after the failing
//                        burst instead of running the remaining bursts.
module dma_w_burst_ctrl #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned LEN_W     = 8,
   parameter int unsigned XFER_W    = 16,
   parameter int unsigned MAX_BURST = 256
) (
   input logic                clk,
   input logic                rst,
   dma_w_burst_ctrl_if.slave  bus
);
   localparam int unsigned B         = DATA_W / 8;
   localparam int unsigned AddrShift = $clog2(B);
   localparam logic [LEN_W:0] BurstOne = (LEN_W+1)'(1);

   typedef enum logic [2:0] {StIdle, StCalc, StIssue, StData, StResp} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [XFER_W-1:0]   remain_q, remain_d;
   logic [LEN_W:0]      burst_q, burst_d;
   logic [LEN_W:0]      beat_cnt_q, beat_cnt_d;
   logic [ADDR_W-1:0]   eng_addr_q, eng_addr_d;
   logic [LEN_W-1:0]    eng_len_q, eng_len_d;
   logic                eng_valid_q, eng_valid_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                error_q, error_d;

   logic [12:0]         to4k;
   logic [31:0]         burst_w;
   logic [LEN_W:0]      burst_calc;
   logic                level_ok;
   logic                unused_src_valid;

   // Beat acceptance is driven purely by eng_ready; src_valid is not consulted.
   assign unused_src_valid = bus.src_valid;

   always_comb begin
      // Beats left before the next 4 KB page; 13 bits so an aligned address gives 4096/B.
      to4k    = (13'h1000 - {1'b0, cur_addr_q[11:0]}) >> AddrShift;
      burst_w = 32'(remain_q);
      if (32'(to4k) < burst_w) burst_w = 32'(to4k);
      if (MAX_BURST < burst_w) burst_w = MAX_BURST;
      burst_calc = (LEN_W+1)'(burst_w);
      level_ok   = 32'(bus.src_level) >= 32'(burst_q);
   end

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      remain_d    = remain_q;
      burst_d     = burst_q;
      beat_cnt_d  = beat_cnt_q;
      eng_addr_d  = eng_addr_q;
      eng_len_d   = eng_len_q;
      eng_valid_d = eng_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      error_d     = error_q;
      unique case (state_q)
         StIdle: begin
            if (bus.cfg_start) begin
               cur_addr_d = bus.cfg_addr;
               remain_d   = bus.cfg_words;
               error_d    = 1'b0;
               busy_d     = 1'b1;
               state_d    = StCalc;
            end
         end
         StCalc: begin
            if (remain_q == '0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = StIdle;
            end else begin
               burst_d    = burst_calc;
               eng_addr_d = cur_addr_q;
               eng_len_d  = LEN_W'(burst_calc - BurstOne);
               beat_cnt_d = '0;
               state_d    = StIssue;
            end
         end
         StIssue: begin
            // Only request once the whole burst is already buffered.
            if (bus.eng_dma_ready && level_ok) begin
               eng_valid_d = 1'b1;
               state_d     = StData;
            end
         end
         StData: begin
            if (bus.eng_ready) begin
               if (beat_cnt_q == burst_q - BurstOne) begin
                  eng_valid_d = 1'b0;
                  beat_cnt_d  = '0;
                  state_d     = StResp;
               end else begin
                  beat_cnt_d = beat_cnt_q + BurstOne;
               end
            end
         end
         StResp: begin
            if (bus.eng_dma_ready) begin
               error_d    = error_q | bus.eng_error;
               cur_addr_d = cur_addr_q + (ADDR_W'(burst_q) << AddrShift);
               remain_d   = remain_q - XFER_W'(burst_q);
               state_d    = StCalc;
`ifdef DMA_W_ERR_ABORT_EN
               if (bus.eng_error) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cur_addr_q  <= '0;
         remain_q    <= '0;
         burst_q     <= '0;
         beat_cnt_q  <= '0;
         eng_addr_q  <= '0;
         eng_len_q   <= '0;
         eng_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         remain_q    <= remain_d;
         burst_q     <= burst_d;
         beat_cnt_q  <= beat_cnt_d;
         eng_addr_q  <= eng_addr_d;
         eng_len_q   <= eng_len_d;
         eng_valid_q <= eng_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.error     = error_q;
   assign bus.eng_valid = eng_valid_q;
   assign bus.eng_addr  = eng_addr_q;
   assign bus.eng_len   = eng_len_q;
   assign bus.eng_wdata = bus.src_data;
   assign bus.eng_wstrb = '1;
   // Zero-latency pop so the source FIFO advances on the same beat the engine takes.
   assign bus.src_ready = (state_q == StData) && bus.eng_ready;
endmodule

// File: tb/tb_dma_w_burst_ctrl.sv
// tb_dma_w_burst_ctrl: directed bench for dma_w_burst_ctrl with a small write
// engine model (beats accepted while rdy_en, fixed response latency) and a
// monitor that records every burst request and every source pop.
module tb_dma_w_burst_ctrl;
   logic clk;
   logic rst;

   dma_w_burst_ctrl_if #(.ADDR_W(32), .DATA_W(32), .LEN_W(8), .XFER_W(16)) bus ();

   dma_w_burst_ctrl #(
      .ADDR_W(32), .DATA_W(32), .LEN_W(8), .XFER_W(16), .MAX_BURST(256)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

`ifdef DMA_W_ERR_ABORT_EN
   localparam int ExpErrBursts = 1;
`else
   localparam int ExpErrBursts = 3;
`endif

   int   n_checks = 0;
   int   n_err    = 0;
   int   n_bursts = 0;
   int   n_pulses = 0;
   logic prev_valid = 1'b0;
   logic [31:0] b_addr [16];
   logic [7:0]  b_len  [16];

   bit   rdy_en   = 1'b1;
   bit   err_mode = 1'b0;
   int   err_base = 0;
   int   eng_st;
   int   eng_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine model: idle -> data while eng_valid -> short response wait -> idle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         eng_st  <= 0;
         eng_cnt <= 0;
      end else begin
         case (eng_st)
            0: if (bus.eng_valid) eng_st <= 1;
            1: if (!bus.eng_valid) begin
                  eng_st  <= 2;
                  eng_cnt <= 2;
               end
            default: if (eng_cnt == 0) eng_st <= 0;
                     else eng_cnt <= eng_cnt - 1;
         endcase
      end
   end

   assign bus.eng_dma_ready = (eng_st == 0);
   assign bus.eng_ready     = bus.eng_valid & rdy_en;
   assign bus.eng_error     = err_mode && (n_bursts == err_base + 1);
   assign bus.src_valid     = 1'b1;
   assign bus.src_data      = 32'hA5A5_1234;

   always @(negedge clk) begin
      if (bus.src_ready === 1'b1) n_pulses <= n_pulses + 1;
      if (bus.eng_valid === 1'b1 && !prev_valid) begin
         if (n_bursts < 16) begin
            b_addr[n_bursts] <= bus.eng_addr;
            b_len[n_bursts]  <= bus.eng_len;
         end
         n_bursts <= n_bursts + 1;
      end
      prev_valid <= bus.eng_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [31:0] a, input logic [15:0] w);
      @(negedge clk);
      bus.cfg_addr  = a;
      bus.cfg_words = w;
      bus.cfg_start = 1'b1;
      @(negedge clk);
      bus.cfg_start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      int k;
      k = 0;
      while (bus.done !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk(tag, 32'(bus.done), 32'd1);
   endtask

   initial begin
      int b0;
      int p0;
      int k;
      bus.cfg_start = 1'b0;
      bus.cfg_addr  = '0;
      bus.cfg_words = '0;
      bus.src_level = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_error", 32'(bus.error), 32'd0);
      chk("rst_eng_valid", 32'(bus.eng_valid), 32'd0);
      chk("rst_src_ready", 32'(bus.src_ready), 32'd0);
      chk("rst_eng_len", 32'(bus.eng_len), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Zero-word transfer: busy for exactly one cycle, done 2 cycles after start.
      b0 = n_bursts;
      start(32'h0000_1000, 16'd0);
      chk("zero_busy_c1", 32'(bus.busy), 32'd1);
      chk("zero_done_c1", 32'(bus.done), 32'd0);
      @(negedge clk);
      chk("zero_done_c2", 32'(bus.done), 32'd1);
      chk("zero_busy_c2", 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("zero_done_c3", 32'(bus.done), 32'd0);
      chk("zero_no_burst", 32'(n_bursts - b0), 32'd0);

      // Single 16-beat burst at 0x1000.
      bus.src_level = 16'd1000;
      b0 = n_bursts;
      p0 = n_pulses;
      start(32'h0000_1000, 16'd16);
      wait_done(300, "one_done");
      chk("one_nbursts", 32'(n_bursts - b0), 32'd1);
      chk("one_addr", b_addr[b0], 32'h0000_1000);
      chk("one_len", 32'(b_len[b0]), 32'd15);
      chk("one_pulses", 32'(n_pulses - p0), 32'd16);
      chk("one_error", 32'(bus.error), 32'd0);
      chk("one_busy_at_done", 32'(bus.busy), 32'd0);

      // 4 KB split: 2 beats before the page, 6 after.
      b0 = n_bursts;
      p0 = n_pulses;
      start(32'h0000_0FF8, 16'd8);
      wait_done(300, "split_done");
      chk("split_nbursts", 32'(n_bursts - b0), 32'd2);
      chk("split_addr0", b_addr[b0], 32'h0000_0FF8);
      chk("split_len0", 32'(b_len[b0]), 32'd1);
      chk("split_addr1", b_addr[b0+1], 32'h0000_1000);
      chk("split_len1", 32'(b_len[b0+1]), 32'd5);
      chk("split_pulses", 32'(n_pulses - p0), 32'd8);

      // 600 words: 256 + 256 + 88.
      b0 = n_bursts;
      start(32'h0000_0000, 16'd600);
      wait_done(2000, "big_done");
      chk("big_nbursts", 32'(n_bursts - b0), 32'd3);
      chk("big_addr0", b_addr[b0], 32'h0000_0000);
      chk("big_len0", 32'(b_len[b0]), 32'd255);
      chk("big_addr1", b_addr[b0+1], 32'h0000_0400);
      chk("big_len1", 32'(b_len[b0+1]), 32'd255);
      chk("big_addr2", b_addr[b0+2], 32'h0000_0800);
      chk("big_len2", 32'(b_len[b0+2]), 32'd87);

      // Error on the first burst of a 600-word transfer.
      err_base = n_bursts;
      err_mode = 1'b1;
      b0 = n_bursts;
      start(32'h0000_0000, 16'd600);
      wait_done(2000, "err_done");
      chk("err_nbursts", 32'(n_bursts - b0), 32'(ExpErrBursts));
      chk("err_flag", 32'(bus.error), 32'd1);
      err_mode = 1'b0;
      repeat (3) @(negedge clk);
      chk("err_sticky", 32'(bus.error), 32'd1);
      start(32'h0000_0000, 16'd0);
      chk("err_cleared", 32'(bus.error), 32'd0);
      wait_done(10, "err_clr_done");

      // Source level below burst size holds off the request.
      bus.src_level = 16'd10;
      b0 = n_bursts;
      start(32'h0000_2000, 16'd16);
      repeat (20) @(negedge clk);
      chk("lvl_valid_low", 32'(bus.eng_valid), 32'd0);
      chk("lvl_no_burst", 32'(n_bursts - b0), 32'd0);
      chk("lvl_busy", 32'(bus.busy), 32'd1);
      bus.src_level = 16'd16;
      wait_done(300, "lvl_done");
      chk("lvl_nbursts", 32'(n_bursts - b0), 32'd1);
      chk("lvl_len", 32'(b_len[b0]), 32'd15);

      // Reset in the middle of the data phase.
      rdy_en = 1'b0;
      start(32'h0000_3000, 16'd16);
      k = 0;
      while (bus.eng_valid !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("mid_valid", 32'(bus.eng_valid), 32'd1);
      rdy_en = 1'b1;
      #1;
      chk("mid_src_ready", 32'(bus.src_ready), 32'd1);
      chk("mid_wdata", bus.eng_wdata, 32'hA5A5_1234);
      chk("mid_wstrb", 32'(bus.eng_wstrb), 32'hF);
      rst = 1'b1;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_valid", 32'(bus.eng_valid), 32'd0);
      chk("mid_rst_src_ready", 32'(bus.src_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
